// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth MAC pipeline.
// Digit encoding, per-beat mode bits, partial product count.
package booth_pkg;

  typedef enum logic [2:0] {
    B_ZERO,
    B_P1,
    B_P2,
    B_M1,
    B_M2
  } booth_op_e;

  typedef struct packed {
    logic acc_en;
    logic first;
  } mode_t;

  function automatic int npp(input int w);
    return w / 2 + 1;
  endfunction

  // Triplet is {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_op_e booth_decode(input logic [2:0] t);
    booth_op_e op;
    unique case (t)
      3'b001, 3'b010: op = B_P1;
      3'b011:         op = B_P2;
      3'b100:         op = B_M2;
      3'b101, 3'b110: op = B_M1;
      default:        op = B_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mac_pipe_if.sv
// Operand/result handshake bundle for booth_mac_pipe.
// master drives operands and out_ready; slave is the MAC.
interface booth_mac_pipe_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             in_acc_en;
  logic             in_acc_first;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b,
    output in_signed, in_acc_en, in_acc_first,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_signed, in_acc_en, in_acc_first,
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/booth_pp_gen.sv
// One Booth digit times the extended multiplicand,
// as an ACC_W-wide partial product already shifted into place.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40,
  parameter int SHIFT = 0
) (
  input  booth_op_e        op,
  input  logic [WIDTH+1:0] a_ext,
  output logic [ACC_W-1:0] pp
);
  logic [ACC_W-1:0] a_w;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] pp_raw;
  logic             neg;

  assign a_w = {{(ACC_W-WIDTH-2){a_ext[WIDTH+1]}}, a_ext};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (op)
      B_P1: mag = a_w;
      B_P2: mag = a_w << 1;
      B_M1: begin
        mag = a_w;
        neg = 1'b1;
      end
      B_M2: begin
        mag = a_w << 1;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp_raw = neg ? (~mag + 1'b1) : mag;
    pp = pp_raw << SHIFT;
  end
endmodule

// File: rtl/booth_mac_pipe.sv
// 3-stage radix-4 Booth multiply-accumulate with valid/ready flow.
// S1 partial products, S2 3:2 CSA chain, S3 final add + accumulate.
module booth_mac_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
) (
  input logic             clk,
  input logic             rst_n,
  booth_mac_pipe_if.slave bus
);
  localparam int NPP = npp(WIDTH);
  localparam int EW  = WIDTH + 2;

  logic             adv;
  logic [EW-1:0]    a_ext;
  logic [EW-1:0]    b_ext;
  logic [EW:0]      b_win;
  mode_t            in_m;
  logic [ACC_W-1:0] pp_c [NPP];

  logic             s1_v;
  mode_t            s1_m;
  logic [ACC_W-1:0] s1_pp [NPP];

  logic [ACC_W-1:0] csa_s;
  logic [ACC_W-1:0] csa_c;

  logic             s2_v;
  mode_t            s2_m;
  logic [ACC_W-1:0] s2_sum;
  logic [ACC_W-1:0] s2_carry;

  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] res;
  logic             out_v_q;
  logic [ACC_W-1:0] out_q;

  assign adv           = !out_v_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_v_q;
  assign bus.out_data  = out_q;

  assign a_ext = bus.in_signed ?
                 {{2{bus.in_a[WIDTH-1]}}, bus.in_a} :
                 {2'b00, bus.in_a};
  assign b_ext = bus.in_signed ?
                 {{2{bus.in_b[WIDTH-1]}}, bus.in_b} :
                 {2'b00, bus.in_b};
  assign b_win = {b_ext, 1'b0};
  assign in_m  = {bus.in_acc_en, bus.in_acc_first};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_op_e op;
    assign op = booth_decode(b_win[2*i+2 -: 3]);
    booth_pp_gen #(
      .WIDTH(WIDTH),
      .ACC_W(ACC_W),
      .SHIFT(2*i)
    ) u_pp (
      .op   (op),
      .a_ext(a_ext),
      .pp   (pp_c[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_m <= '0;
      for (int k = 0; k < NPP; k++) s1_pp[k] <= '0;
    end else if (adv) begin
      s1_v <= bus.in_valid;
      s1_m <= in_m;
      for (int k = 0; k < NPP; k++) s1_pp[k] <= pp_c[k];
    end
  end

  // Each row folds one more partial product into the sum/carry pair
  for (genvar r = 0; r < NPP - 2; r++) begin : g_csa
    logic [ACC_W-1:0] x, y, z, s, c, maj;
    if (r == 0) begin : g_head
      assign x = s1_pp[0];
      assign y = s1_pp[1];
    end else begin : g_link
      assign x = g_csa[r-1].s;
      assign y = g_csa[r-1].c;
    end
    assign z   = s1_pp[r+2];
    assign s   = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    assign c   = maj << 1;
  end

  assign csa_s = g_csa[NPP-3].s;
  assign csa_c = g_csa[NPP-3].c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_m     <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
    end else if (adv) begin
      s2_v     <= s1_v;
      s2_m     <= s1_m;
      s2_sum   <= csa_s;
      s2_carry <= csa_c;
    end
  end

  always_comb begin
    prod    = s2_sum + s2_carry;
    acc_nxt = acc_q;
    res     = prod;
    if (s2_m.acc_en) begin
      acc_nxt = s2_m.first ? prod : acc_q + prod;
      res     = acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q <= 1'b0;
      out_q   <= '0;
      acc_q   <= '0;
    end else if (adv) begin
      out_v_q <= s2_v;
      if (s2_v) begin
        out_q <= res;
        acc_q <= acc_nxt;
      end
    end
  end
endmodule
